audio_i2s_timing: RTL and testbench

AUDIO_I2S_TIMING -- requirements
Module: audio_i2s_timing

---
 rtl/audio_i2s_timing.sv | 147 ++++++++++++++
 tb/tb_audio_i2s_timing.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_timing.sv
// I2S master timing (BCLK/LRCK from registered counters) with optional DAC-data capture; all outputs are flops.
// Macro AUDIO_I2S_CAPTURE_EN enables capture; no backpressure, frame_tick and sample_valid are one-cycle pulses.
module audio_i2s_timing #(
  parameter int CLK_DIV   = 2,
  parameter int SLOT_BITS = 32,
  parameter int DATA_W    = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  output logic              bclk,
  output logic              lrck,
  input  logic              dacdat,
  output logic              running,
  output logic              frame_tick,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              sample_valid
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             running_q, running_d;
  logic             frame_tick_q, frame_tick_d;
  logic             active, div_last, bclk_fall, slot_end, frame_end;

  always_comb begin
    active       = (state_q != ST_IDLE);
    div_last     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    bclk_fall    = active && div_last && bclk_q;
    slot_end     = bclk_fall && (bit_cnt_q == BIT_W'(SLOT_BITS - 1));
    frame_end    = slot_end && lrck_q;
    state_d      = state_q;
    div_cnt_d    = '0;
    bit_cnt_d    = '0;
    bclk_d       = 1'b0;
    lrck_d       = 1'b0;
    frame_tick_d = 1'b0;
    if (active) begin
      div_cnt_d    = div_last ? '0 : div_cnt_q + 1'b1;
      bclk_d       = div_last ? ~bclk_q : bclk_q;
      bit_cnt_d    = slot_end ? '0 : (bclk_fall ? bit_cnt_q + 1'b1 : bit_cnt_q);
      lrck_d       = slot_end ? ~lrck_q : lrck_q;
      frame_tick_d = frame_end;
      // Stopping only ever exits on a frame boundary, where every counter wraps to 0 anyway.
      if (enable) begin
        state_d = ST_RUN;
      end else if (frame_end) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_STOPPING;
      end
    end else if (enable) begin
      state_d = ST_RUN;
    end
    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      running_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      running_q    <= running_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrck       = lrck_q;
  assign running    = running_q;
  assign frame_tick = frame_tick_q;

`ifdef AUDIO_I2S_CAPTURE_EN
  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic              sample_valid_q, sample_valid_d;
  logic              bclk_rise, data_bit;

  always_comb begin
    bclk_rise      = active && div_last && !bclk_q;
    // Slot bit 0 is the LRCK-edge bit; the word occupies bits 1..DATA_W, MSB first.
    data_bit       = (bit_cnt_q >= BIT_W'(1)) && (bit_cnt_q <= BIT_W'(DATA_W));
    sh_l_d         = sh_l_q;
    sh_r_d         = sh_r_q;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    sample_valid_d = 1'b0;
    if (!active) begin
      sh_l_d = '0;
      sh_r_d = '0;
    end else begin
      if (bclk_rise && data_bit && !lrck_q) sh_l_d = {sh_l_q[DATA_W-2:0], dacdat};
      if (bclk_rise && data_bit && lrck_q)  sh_r_d = {sh_r_q[DATA_W-2:0], dacdat};
      if (frame_end) begin
        sample_l_d     = sh_l_q;
        sample_r_d     = sh_r_q;
        sample_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sh_l_q         <= '0;
      sh_r_q         <= '0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sh_l_q         <= sh_l_d;
      sh_r_q         <= sh_r_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = sample_valid_q;
`else
  logic unused_dacdat;
  assign unused_dacdat = dacdat;
  assign sample_l      = '0;
  assign sample_r      = '0;
  assign sample_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_i2s_timing.sv
// Directed bench for audio_i2s_timing: default instance plus a CLK_DIV=3 / SLOT_BITS=16 instance.
module tb_audio_i2s_timing;
`ifdef AUDIO_I2S_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic        dacdat = 1'b0;
  logic        dacdat2 = 1'b1;
  logic        bclk, lrck, running, frame_tick, sample_valid;
  logic [23:0] sample_l, sample_r;
  logic        bclk2, lrck2, running2, frame_tick2, sample_valid2;
  logic [11:0] sample_l2, sample_r2;

  logic [23:0] wl_word = 24'hA5A5A5;
  logic [23:0] wr_word = 24'h3C0F81;

  int vectors = 0;
  int errors  = 0;
  int edges   = 0;
  int t0      = 0;

  audio_i2s_timing dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .bclk(bclk), .lrck(lrck), .dacdat(dacdat), .running(running),
    .frame_tick(frame_tick), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid)
  );

  audio_i2s_timing #(.CLK_DIV(3), .SLOT_BITS(16), .DATA_W(12)) dut2 (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable2),
    .bclk(bclk2), .lrck(lrck2), .dacdat(dacdat2), .running(running2),
    .frame_tick(frame_tick2), .sample_l(sample_l2), .sample_r(sample_r2),
    .sample_valid(sample_valid2)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) edges <= edges + 1;

  // Event log, sampled on the falling clock edge.
  int   rise_q[$], lrise_q[$], lfall_q[$], tick_q[$], valid_q[$];
  int   rise2_q[$], lrise2_q[$], tick2_q[$];
  int   bad_gap = 0, bad_lrck = 0, last_rise = -1;
  logic bclk_p = 1'b0, lrck_p = 1'b0, bclk2_p = 1'b0, lrck2_p = 1'b0;

  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (bclk && !bclk_p) begin
        rise_q.push_back(edges);
        if (last_rise >= 0 && edges - last_rise != 4) bad_gap++;
        last_rise = edges;
      end
      if (!running) last_rise = -1;
      if (lrck != lrck_p && !(bclk_p && !bclk)) bad_lrck++;
      if (lrck && !lrck_p) lrise_q.push_back(edges);
      if (!lrck && lrck_p) lfall_q.push_back(edges);
      if (frame_tick) tick_q.push_back(edges);
      if (sample_valid) valid_q.push_back(edges);
      if (bclk2 && !bclk2_p) rise2_q.push_back(edges);
      if (lrck2 && !lrck2_p) lrise2_q.push_back(edges);
      if (frame_tick2) tick2_q.push_back(edges);
    end else begin
      last_rise = -1;
    end
    bclk_p  = bclk;
    lrck_p  = lrck;
    bclk2_p = bclk2;
    lrck2_p = lrck2;
  end

  function automatic int qa(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Codec-side serial data: I2S with ignored slot bits driven high.
  function automatic logic dac_bit(input int t);
    int          p, b;
    logic [23:0] w;
    if (t < 0) return 1'b0;
    p = (t % 256) / 4;
    b = p % 32;
    w = (p >= 32) ? wr_word : wl_word;
    if (b >= 1 && b <= 24) return w[24 - b];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_clk);
      dacdat = dac_bit(edges - t0);
    end
  endtask

  task automatic step_until(input int target);
    while (edges < target) step(1);
  endtask

  initial begin
    int drops;
    int nrise;
    #1 reset_reset_n = 1'b0;
    step(3);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_running", running, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample_l", sample_l, 0);
    chk("rst_sample_r", sample_r, 0);

    reset_reset_n = 1'b1;
    step(5);
    chk("idle_running", running, 0);
    chk("idle_no_bclk", rise_q.size(), 0);

    // Continuous run, both instances enter RUN on the same edge.
    enable  = 1'b1;
    enable2 = 1'b1;
    t0 = edges + 1;
    step(1);
    chk("run_entry", running, 1);
    step_until(t0 + 600);
    chk("first_rise", qa(rise_q, 0) - t0, 2);
    chk("bclk_period", qa(rise_q, 1) - qa(rise_q, 0), 4);
    chk("lrck_rise", qa(lrise_q, 0) - t0, 128);
    chk("lrck_fall", qa(lfall_q, 0) - t0, 256);
    chk("tick0", qa(tick_q, 0) - t0, 256);
    chk("tick_period", qa(tick_q, 1) - qa(tick_q, 0), 256);
    chk("tick_count", tick_q.size(), 2);
    chk("valid_count", valid_q.size(), CAP ? 2 : 0);
    chk("valid_at_tick", qa(valid_q, 0), CAP ? qa(tick_q, 0) : -1);
    chk("sample_l", sample_l, CAP ? 24'hA5A5A5 : 24'h0);
    chk("sample_r", sample_r, CAP ? 24'h3C0F81 : 24'h0);
    chk("d2_first_rise", qa(rise2_q, 0) - t0, 3);
    chk("d2_bclk_period", qa(rise2_q, 1) - qa(rise2_q, 0), 6);
    chk("d2_lrck_rise", qa(lrise2_q, 0) - t0, 96);
    chk("d2_tick0", qa(tick2_q, 0) - t0, 192);
    chk("d2_frame", qa(tick2_q, 1) - qa(tick2_q, 0), 192);
    chk("d2_sample_l", sample_l2, CAP ? 12'hFFF : 12'h0);
    chk("d2_sample_valid_cnt", sample_valid2, 0);

    // Stop 100 cycles into the frame starting at t0+768.
    step_until(t0 + 768 + 100);
    enable = 1'b0;
    tick_q.delete();
    valid_q.delete();
    step(50);
    chk("stopping_running", running, 1);
    step_until(t0 + 1024 + 5);
    chk("stop_tick_count", tick_q.size(), 1);
    chk("stop_tick_time", qa(tick_q, 0) - t0, 1024);
    chk("stop_valid_time", qa(valid_q, 0) - t0, CAP ? 1024 : -1 - t0);
    chk("stop_running", running, 0);
    chk("stop_bclk", bclk, 0);
    chk("stop_lrck", lrck, 0);
    chk("stop_sample_r", sample_r, CAP ? 24'h3C0F81 : 24'h0);
    nrise = rise_q.size();
    step(20);
    chk("idle_holds", rise_q.size(), nrise);

    // Restart, then drop enable briefly inside the first frame.
    enable = 1'b1;
    t0 = edges + 1;
    step(1);
    step_until(t0 + 100);
    enable = 1'b0;
    tick_q.delete();
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!running) drops++;
    end
    enable = 1'b1;
    while (edges < t0 + 512 + 10) begin
      step(1);
      if (!running) drops++;
    end
    chk("resume_running", drops, 0);
    chk("resume_tick0", qa(tick_q, 0) - t0, 256);
    chk("resume_tick1", qa(tick_q, 1) - t0, 512);
    chk("resume_gap", bad_gap, 0);
    chk("lrck_on_bclk_fall", bad_lrck, 0);

    // Reset pulse in the right slot of the next frame.
    step_until(t0 + 512 + 128 + 50);
    chk("pre_rst_lrck", lrck, 1);
    chk("pre_rst_sample_l", sample_l, CAP ? 24'hA5A5A5 : 24'h0);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("arst_bclk_lrck", {bclk, lrck, running, frame_tick, sample_valid}, 0);
    chk("arst_sample_l", sample_l, 0);
    chk("arst_sample_r", sample_r, 0);
    step(2);
    reset_reset_n = 1'b1;
    tick_q.delete();
    valid_q.delete();
    t0 = edges + 1;
    step(1);
    step_until(t0 + 260);
    chk("post_rst_tick", qa(tick_q, 0) - t0, 256);
    chk("post_rst_valid", qa(valid_q, 0) - t0, CAP ? 256 : -1 - t0);
    chk("post_rst_sample_l", sample_l, CAP ? 24'hA5A5A5 : 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
